// File: rtl/spi_master_ctrl.sv
// SPI master transaction controller, CPOL=0, LSB first.
// Generates sclk, cs_n and mosi for one DATA_WIDTH-bit word per start and
// drives the enable of the downstream receive shift register, which samples
// on the falling edge of sclk.
module spi_master_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  rx_en
);

  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD
  } state_t;

  state_t                state, state_d;
  logic [DIV_W-1:0]      div_cnt, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shreg, tx_shreg_d;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic                  sclk_d, mosi_d, cs_n_d, busy_d, done_d, rx_en_d;
  logic                  tick;

  // A tick marks the end of one sclk half-period; the divider is parked in IDLE.
  assign tick       = (state != IDLE) && (div_cnt == DIV_LAST);
  assign tx_shifted = tx_shreg >> bit_cnt;

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_d    = state;
    div_cnt_d  = '0;
    bit_cnt_d  = bit_cnt;
    tx_shreg_d = tx_shreg;
    sclk_d     = sclk;
    mosi_d     = mosi;
    cs_n_d     = cs_n;
    busy_d     = busy;
    done_d     = 1'b0;
    rx_en_d    = rx_en;

    if (state != IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          tx_shreg_d = tx_data;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          rx_en_d    = 1'b1;
          mosi_d     = tx_data[0];
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          mosi_d  = tx_shreg[0];
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        if (tick) begin
          if (!sclk) begin
            sclk_d = 1'b1;
            mosi_d = tx_shifted[0];
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = HOLD;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        sclk_d = 1'b0;
        if (tick) begin
          cs_n_d  = 1'b1;
          rx_en_d = 1'b0;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and all outputs are registered; reset aborts any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shreg <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_en    <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      tx_shreg <= tx_shreg_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
      busy     <= busy_d;
      done     <= done_d;
      rx_en    <= rx_en_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: lane 0 uses CLK_DIV=4, lane 1 CLK_DIV=2.
// Stimulus pushes the expected word and latency; per-lane monitors rebuild the
// serial stream, model the receive shift register and compare on every done.
module tb_spi_master_ctrl;

  typedef struct {
    int         lane;
    logic [7:0] data;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start = '0;
  logic [7:0] tx_data [2];
  logic [1:0] busy, done, sclk, mosi, cs_n, rx_en;

  exp_t exp_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  spi_master_ctrl #(.CLK_DIV(4), .DATA_WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start[0]),
    .tx_data (tx_data[0]),
    .busy    (busy[0]),
    .done    (done[0]),
    .sclk    (sclk[0]),
    .mosi    (mosi[0]),
    .cs_n    (cs_n[0]),
    .rx_en   (rx_en[0])
  );

  spi_master_ctrl #(.CLK_DIV(2), .DATA_WIDTH(8)) dut_fast (
    .clk     (clk),
    .rst     (rst),
    .start   (start[1]),
    .tx_data (tx_data[1]),
    .busy    (busy[1]),
    .done    (done[1]),
    .sclk    (sclk[1]),
    .mosi    (mosi[1]),
    .cs_n    (cs_n[1]),
    .rx_en   (rx_en[1])
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Cycle counter used to time events relative to cs_n assertion.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int lane, input logic [7:0] data, input bit track, input int lat);
    exp_t e;
    tx_data[lane] = data;
    start[lane]   = 1'b1;
    if (track) begin
      e.lane = lane;
      e.data = data;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start[lane] = 1'b0;
  endtask

  task automatic waitDone(input int lane);
    int n;
    n = 0;
    while (done[lane] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_budget", 32'(n < 300), 1);
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int N = (g == 0) ? 4 : 2;
    logic [7:0] rx_reg;
    logic [7:0] got = '0;
    logic       sclk_q = 1'b0;
    logic       csn_q = 1'b1;
    logic       done_q = 1'b0;
    logic       mosi_hi = 1'b0;
    int         t0 = 0;
    int         rises = 0;
    int         falls = 0;
    int         last_rise = 0;
    int         first_rise = -1;
    int         pmin = 999;
    int         pmax = 0;
    int         viol = 0;
    exp_t       e;

    // Downstream receive right-shift register, sampling mosi on falling sclk.
    always @(negedge sclk[g] or posedge rst) begin
      if (rst) rx_reg <= '0;
      else if (rx_en[g]) rx_reg <= {mosi[g], rx_reg[7:1]};
    end

    // Monitor: track sclk edges and protocol invariants, score each done pulse.
    always @(negedge clk) begin
      if (rst) begin
        sclk_q = 1'b0;
        csn_q  = 1'b1;
        done_q = 1'b0;
      end else begin
        if (csn_q && !cs_n[g]) begin
          checkOutput("csn_fall_expected", 32'(exp_q.size() > 0), 1);
          t0         = cyc;
          rises      = 0;
          falls      = 0;
          got        = '0;
          first_rise = -1;
          pmin       = 999;
          pmax       = 0;
        end
        if (!sclk_q && sclk[g]) begin
          rises++;
          if (rises == 1) begin
            first_rise = cyc - t0;
          end else begin
            if (cyc - last_rise < pmin) pmin = cyc - last_rise;
            if (cyc - last_rise > pmax) pmax = cyc - last_rise;
          end
          last_rise = cyc;
        end
        if (sclk_q && !sclk[g]) begin
          falls++;
          got = {mosi[g], got[7:1]};
          if (mosi[g] !== mosi_hi) viol++;
        end
        if (sclk[g]) mosi_hi = mosi[g];
        if (cs_n[g] && sclk[g]) viol++;
        if (busy[g] !== ~cs_n[g] || rx_en[g] !== ~cs_n[g]) viol++;
        if (done_q && done[g]) viol++;
        if (done[g]) begin
          checkOutput("done_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("done_lane", g, e.lane);
            checkOutput("mosi_stream", {24'd0, got}, {24'd0, e.data});
            checkOutput("rx_register", {24'd0, rx_reg}, {24'd0, e.data});
            checkOutput("done_latency", cyc - t0, e.lat);
            checkOutput("sclk_rises", rises, 8);
            checkOutput("sclk_falls", falls, 8);
            checkOutput("first_rise", first_rise, N);
            checkOutput("sclk_period_min", pmin, 2 * N);
            checkOutput("sclk_period_max", pmax, 2 * N);
          end
        end
        sclk_q = sclk[g];
        csn_q  = cs_n[g];
        done_q = done[g];
      end
    end
  end

  // Directed sequence: one block per scenario, expectations hand-computed.
  initial begin
    tx_data[0] = '0;
    tx_data[1] = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_sclk", sclk[0], 0);
    checkOutput("rst_cs_n", cs_n[0], 1);
    checkOutput("rst_mosi", mosi[0], 0);
    checkOutput("rst_busy", busy[0], 0);
    checkOutput("rst_done", done[0], 0);
    checkOutput("rst_rx_en", rx_en[0], 0);
    checkOutput("rst_cs_n_fast", cs_n[1], 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] basic transfer 0xA5");
    applyStimulus(0, 8'hA5, 1, 68);
    checkOutput("busy_after_start", busy[0], 1);
    checkOutput("csn_after_start", cs_n[0], 0);
    checkOutput("mosi_first_bit", mosi[0], 1);
    waitDone(0);
    repeat (5) @(negedge clk);

    $display("[TB] loopback 0x3C");
    applyStimulus(0, 8'h3C, 1, 68);
    waitDone(0);
    repeat (20) @(negedge clk);
    checkOutput("rx_hold_after_idle", {24'd0, mon[0].rx_reg}, 32'h3C);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 8'hFF, 1, 68);
    repeat (19) @(negedge clk);
    applyStimulus(0, 8'h00, 0, 0);
    waitDone(0);
    repeat (100) @(negedge clk);
    checkOutput("csn_idle_after_reject", cs_n[0], 1);

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 8'h81, 1, 68);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_sclk", sclk[0], 0);
    checkOutput("abort_cs_n", cs_n[0], 1);
    checkOutput("abort_busy", busy[0], 0);
    checkOutput("abort_rx_en", rx_en[0], 0);
    checkOutput("abort_done", done[0], 0);
    checkOutput("abort_mosi", mosi[0], 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(0, 8'h81, 1, 68);
    waitDone(0);
    repeat (5) @(negedge clk);

    $display("[TB] back-to-back 0x34 then 0x12");
    applyStimulus(0, 8'h34, 1, 68);
    waitDone(0);
    checkOutput("b2b_csn_high_in_done", cs_n[0], 1);
    applyStimulus(0, 8'h12, 1, 68);
    checkOutput("b2b_csn_low_next", cs_n[0], 0);
    waitDone(0);
    repeat (5) @(negedge clk);

    $display("[TB] minimum divider 0x01");
    applyStimulus(1, 8'h01, 1, 34);
    waitDone(1);
    repeat (10) @(negedge clk);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("lane0_invariants", mon[0].viol, 0);
    checkOutput("lane1_invariants", mon[1].viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
